// File: rtl/lpif_ll_credit_buffer.sv
// Logic-link layer between the user name block and the PHY concat block.
// Ports: clk_wr/rst_wr_n; rx_online/tx_online link-up; rx_push/rx_data in from the PHY;
//   rxfifo_valid/ready/data out to the user; tx_credit_return to the far end;
//   tx_valid/ready/data in from the user; tx_push/tx_phy_data out to the PHY;
//   rx_credit_return credits back from the far end; init_upstream_credit; debug_status.
// RX: push to rxfifo_valid is 1 cycle; rxfifo_data is combinational from the head entry.
// TX: tx_data to tx_phy_data is 1 cycle. tx_ready drops when credit is exhausted.
module lpif_ll_credit_buffer #(
    parameter int DATA_WIDTH   = 281,
    parameter int DEPTH        = 16,
    parameter int CREDIT_WIDTH = 8
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    input  logic                    rx_online,
    input  logic                    tx_online,
    input  logic [CREDIT_WIDTH-1:0] init_upstream_credit,
    input  logic                    rx_push,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    rxfifo_valid,
    input  logic                    rxfifo_ready,
    output logic [DATA_WIDTH-1:0]   rxfifo_data,
    output logic                    tx_credit_return,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_push,
    output logic [DATA_WIDTH-1:0]   tx_phy_data,
    input  logic                    rx_credit_return,
    output logic [31:0]             debug_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_OFFLINE = 2'd0,
        ST_LOAD    = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    // ---------------- RX FIFO ----------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_rx_ovf;
    logic                  r_credit_ret;

    logic w_full, w_valid, w_pop, w_push, w_wr;

    assign w_full  = (r_count == FULL_CNT);
    // Offline masks valid immediately, so no pop and hence no credit return can occur.
    assign w_valid = rx_online & (r_count != '0);
    assign w_pop   = w_valid & rxfifo_ready;
    assign w_push  = rx_push & rx_online;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_wr    = w_push & (~w_full | w_pop);

    assign rxfifo_valid     = w_valid;
    // Zero when empty so every output reads 0 straight out of reset.
    assign rxfifo_data      = w_valid ? r_mem[r_rd_ptr] : '0;
    assign tx_credit_return = r_credit_ret;

    always_ff @(posedge clk_wr) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rx_ovf     <= 1'b0;
            r_credit_ret <= 1'b0;
        end else if (!rx_online) begin
            // Link down flushes the FIFO; the overflow flag survives.
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_credit_ret <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_rx_ovf <= 1'b1;
            end
            r_credit_ret <= w_pop;
        end
    end

    // ---------------- TX credit FSM ----------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic [CREDIT_WIDTH-1:0] w_credit_nxt;
    logic                    r_credit_ovf;
    logic                    w_credit_ovf_set;
    logic                    w_send;
    logic                    w_tx_rdy;
    logic                    r_tx_push;
    logic [DATA_WIDTH-1:0]   r_tx_phy_data;
    logic [31:0]             r_debug;

    always_comb begin
        w_state_nxt      = r_state;
        w_credit_nxt     = r_credit;
        w_tx_rdy         = 1'b0;
        w_send           = 1'b0;
        w_credit_ovf_set = 1'b0;
        case (r_state)
            ST_OFFLINE: begin
                w_credit_nxt = '0;
                w_state_nxt  = ST_LOAD;
            end
            ST_LOAD: begin
                w_credit_nxt = init_upstream_credit;
                w_state_nxt  = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                w_tx_rdy = (r_credit != '0);
                w_send   = w_tx_rdy & tx_valid;
                if (w_send && !rx_credit_return) begin
                    w_credit_nxt = r_credit - CREDIT_WIDTH'(1);
                end else if (!w_send && rx_credit_return) begin
                    // Saturate rather than wrap; a send+return pair nets to zero.
                    if (r_credit == '1) begin
                        w_credit_ovf_set = 1'b1;
                    end else begin
                        w_credit_nxt = r_credit + CREDIT_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_OFFLINE;
                w_credit_nxt = '0;
            end
        endcase
        // Link down overrides everything, including a handshake in this cycle.
        if (!tx_online) begin
            w_state_nxt      = ST_OFFLINE;
            w_credit_nxt     = '0;
            w_tx_rdy         = 1'b0;
            w_send           = 1'b0;
            w_credit_ovf_set = 1'b0;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_state       <= ST_OFFLINE;
            r_credit      <= '0;
            r_credit_ovf  <= 1'b0;
            r_tx_push     <= 1'b0;
            r_tx_phy_data <= '0;
            r_debug       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_credit  <= w_credit_nxt;
            r_tx_push <= w_send;
            if (w_send) begin
                r_tx_phy_data <= tx_data;
            end
            if (w_credit_ovf_set) begin
                r_credit_ovf <= 1'b1;
            end
            r_debug <= {8'(r_count), 8'(r_credit), r_rx_ovf, r_credit_ovf,
                        2'(r_state), rx_online, tx_online, 10'b0};
        end
    end

    assign tx_ready     = w_tx_rdy;
    assign tx_push      = r_tx_push;
    assign tx_phy_data  = r_tx_phy_data;
    assign debug_status = r_debug;

endmodule

// File: tb/tb_lpif_ll_credit_buffer.sv
// Directed bench for lpif_ll_credit_buffer: RX FIFO fill/overflow/flush and TX credit FSM.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same offset.
// Each scenario task makes its own comparisons and bumps n_pass / n_total.
module tb_lpif_ll_credit_buffer;

    localparam int DW = 281;
    localparam int CRW = 8;

    logic           clk_wr = 1'b0;
    logic           rst_wr_n;
    logic           rx_online;
    logic           tx_online;
    logic [CRW-1:0] init_upstream_credit;
    logic           rx_push;
    logic [DW-1:0]  rx_data;
    logic           rxfifo_valid;
    logic           rxfifo_ready;
    logic [DW-1:0]  rxfifo_data;
    logic           tx_credit_return;
    logic           tx_valid;
    logic           tx_ready;
    logic [DW-1:0]  tx_data;
    logic           tx_push;
    logic [DW-1:0]  tx_phy_data;
    logic           rx_credit_return;
    logic [31:0]    debug_status;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_ll_credit_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .CREDIT_WIDTH(CRW)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online), .tx_online(tx_online),
        .init_upstream_credit(init_upstream_credit), .rx_push(rx_push), .rx_data(rx_data),
        .rxfifo_valid(rxfifo_valid), .rxfifo_ready(rxfifo_ready), .rxfifo_data(rxfifo_data),
        .tx_credit_return(tx_credit_return), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_push(tx_push), .tx_phy_data(tx_phy_data),
        .rx_credit_return(rx_credit_return), .debug_status(debug_status)
    );

    function automatic logic [DW-1:0] mk(input int i);
        logic [31:0] v;
        v  = i;
        mk = {v[24:0], {8{v ^ 32'h5A5A_0000}}};
    endfunction

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic test_reset();
        rst_wr_n = 1'b0; rx_online = 1'b0; tx_online = 1'b0; init_upstream_credit = '0;
        rx_push = 1'b0; rx_data = '0; rxfifo_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
        rx_credit_return = 1'b0;
        step(); step();
        n_total++; if (rxfifo_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", rxfifo_valid); else n_pass++;
        n_total++; if (rxfifo_data !== '0) $display("FAIL reset_rxdata: got %h exp 0", rxfifo_data); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b exp 0", tx_ready); else n_pass++;
        n_total++; if (tx_push !== 1'b0) $display("FAIL reset_tx_push: got %b exp 0", tx_push); else n_pass++;
        n_total++; if (tx_credit_return !== 1'b0) $display("FAIL reset_credit_ret: got %b exp 0", tx_credit_return); else n_pass++;
        n_total++; if (debug_status !== 32'h0) $display("FAIL reset_debug: got %h exp 0", debug_status); else n_pass++;
        rst_wr_n = 1'b1;
        step();
    endtask

    task automatic test_rx_fill_overflow();
        rx_online = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            rx_push = 1'b1; rx_data = mk(i);
            step();
        end
        rx_push = 1'b0;
        n_total++; if (rxfifo_valid !== 1'b1) $display("FAIL fill_valid: got %b exp 1", rxfifo_valid); else n_pass++;
        n_total++; if (rxfifo_data !== mk(0)) $display("FAIL fill_head: got %h exp %h", rxfifo_data, mk(0)); else n_pass++;
        rx_push = 1'b1; rx_data = mk(99);
        step();
        rx_push = 1'b0;
        step();
        n_total++; if (debug_status[15] !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", debug_status[15]); else n_pass++;
        n_total++; if (debug_status[31:24] !== 8'd16) $display("FAIL ovf_count: got %0d exp 16", debug_status[31:24]); else n_pass++;
        n_total++; if (rxfifo_data !== mk(0)) $display("FAIL ovf_head: got %h exp %h", rxfifo_data, mk(0)); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        int pulses;
        logic [DW-1:0] exp_d;
        rx_push = 1'b1; rx_data = mk(100); rxfifo_ready = 1'b1;
        step();
        rx_push = 1'b0; rxfifo_ready = 1'b0;
        n_total++; if (tx_credit_return !== 1'b1) $display("FAIL pp_credit_pulse: got %b exp 1", tx_credit_return); else n_pass++;
        n_total++; if (rxfifo_data !== mk(1)) $display("FAIL pp_head: got %h exp %h", rxfifo_data, mk(1)); else n_pass++;
        step();
        n_total++; if (tx_credit_return !== 1'b0) $display("FAIL pp_pulse_len: got %b exp 0", tx_credit_return); else n_pass++;
        n_total++; if (debug_status[31:24] !== 8'd16) $display("FAIL pp_count: got %0d exp 16", debug_status[31:24]); else n_pass++;
        pulses = 0;
        rxfifo_ready = 1'b1;
        #1;
        for (int j = 0; j < 16; j++) begin
            exp_d = (j < 15) ? mk(j + 1) : mk(100);
            n_total++; if (rxfifo_data !== exp_d) $display("FAIL drain_word%0d: got %h exp %h", j, rxfifo_data, exp_d); else n_pass++;
            step();
            if (tx_credit_return === 1'b1) pulses++;
        end
        rxfifo_ready = 1'b0;
        n_total++; if (pulses !== 16) $display("FAIL drain_pulses: got %0d exp 16", pulses); else n_pass++;
        n_total++; if (rxfifo_valid !== 1'b0) $display("FAIL drain_empty: got %b exp 0", rxfifo_valid); else n_pass++;
        step();
        n_total++; if (tx_credit_return !== 1'b0) $display("FAIL drain_pulse_end: got %b exp 0", tx_credit_return); else n_pass++;
    endtask

    task automatic test_tx_credit();
        int pushes;
        init_upstream_credit = 8'd3; tx_valid = 1'b1; tx_data = mk(200); tx_online = 1'b1;
        step();
        n_total++; if (tx_ready !== 1'b0) $display("FAIL load_ready: got %b exp 0", tx_ready); else n_pass++;
        step();
        pushes = 0;
        for (int i = 0; i < 8; i++) begin
            tx_data = mk(200 + i);
            step();
            if (tx_push === 1'b1) pushes++;
        end
        n_total++; if (pushes !== 3) $display("FAIL tx_push_count: got %0d exp 3", pushes); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL tx_exhausted_ready: got %b exp 0", tx_ready); else n_pass++;
        n_total++; if (tx_phy_data !== mk(202)) $display("FAIL tx_last_data: got %h exp %h", tx_phy_data, mk(202)); else n_pass++;
        n_total++; if (debug_status[23:16] !== 8'd0) $display("FAIL tx_credit_zero: got %0d exp 0", debug_status[23:16]); else n_pass++;
        n_total++; if (debug_status[13:12] !== 2'd2) $display("FAIL tx_state_active: got %0d exp 2", debug_status[13:12]); else n_pass++;
    endtask

    task automatic test_credit_return();
        rx_credit_return = 1'b1;
        step();
        rx_credit_return = 1'b0;
        #1;
        n_total++; if (tx_ready !== 1'b1) $display("FAIL ret_ready: got %b exp 1", tx_ready); else n_pass++;
        step();
        n_total++; if (tx_push !== 1'b1) $display("FAIL ret_send: got %b exp 1", tx_push); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL ret_ready_after: got %b exp 0", tx_ready); else n_pass++;
        tx_valid = 1'b0; rx_credit_return = 1'b1;
        step(); step();
        tx_valid = 1'b1;
        step();
        n_total++; if (tx_push !== 1'b1) $display("FAIL simul_send: got %b exp 1", tx_push); else n_pass++;
        tx_valid = 1'b0; rx_credit_return = 1'b0;
        step();
        n_total++; if (debug_status[23:16] !== 8'd2) $display("FAIL simul_credit: got %0d exp 2", debug_status[23:16]); else n_pass++;
        n_total++; if (tx_ready !== 1'b1) $display("FAIL simul_ready: got %b exp 1", tx_ready); else n_pass++;
    endtask

    task automatic test_credit_saturate();
        tx_online = 1'b0; tx_valid = 1'b0;
        step();
        init_upstream_credit = 8'd255; tx_online = 1'b1;
        step(); step();
        rx_credit_return = 1'b1;
        step();
        rx_credit_return = 1'b0;
        step();
        n_total++; if (debug_status[23:16] !== 8'd255) $display("FAIL sat_credit: got %0d exp 255", debug_status[23:16]); else n_pass++;
        n_total++; if (debug_status[14] !== 1'b1) $display("FAIL sat_flag: got %b exp 1", debug_status[14]); else n_pass++;
        tx_valid = 1'b1; tx_online = 1'b0;
        #1;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL drop_ready: got %b exp 0", tx_ready); else n_pass++;
        step();
        n_total++; if (tx_push !== 1'b0) $display("FAIL drop_no_send: got %b exp 0", tx_push); else n_pass++;
        step();
        tx_valid = 1'b0;
        n_total++; if (debug_status[23:16] !== 8'd0) $display("FAIL drop_credit: got %0d exp 0", debug_status[23:16]); else n_pass++;
        n_total++; if (debug_status[13:12] !== 2'd0) $display("FAIL drop_state: got %0d exp 0", debug_status[13:12]); else n_pass++;
    endtask

    task automatic test_rx_flush();
        for (int i = 0; i < 5; i++) begin
            rx_push = 1'b1; rx_data = mk(300 + i);
            step();
        end
        rx_push = 1'b0;
        n_total++; if (rxfifo_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b exp 1", rxfifo_valid); else n_pass++;
        step();
        n_total++; if (debug_status[31:24] !== 8'd5) $display("FAIL flush_pre_count: got %0d exp 5", debug_status[31:24]); else n_pass++;
        rx_online = 1'b0; rxfifo_ready = 1'b1;
        #1;
        n_total++; if (rxfifo_valid !== 1'b0) $display("FAIL flush_valid: got %b exp 0", rxfifo_valid); else n_pass++;
        step();
        n_total++; if (tx_credit_return !== 1'b0) $display("FAIL flush_no_credit: got %b exp 0", tx_credit_return); else n_pass++;
        rx_online = 1'b1; rxfifo_ready = 1'b0;
        #1;
        n_total++; if (rxfifo_valid !== 1'b0) $display("FAIL flush_empty: got %b exp 0", rxfifo_valid); else n_pass++;
        step();
        n_total++; if (debug_status[31:24] !== 8'd0) $display("FAIL flush_count: got %0d exp 0", debug_status[31:24]); else n_pass++;
        n_total++; if (debug_status[15] !== 1'b1) $display("FAIL flush_ovf_kept: got %b exp 1", debug_status[15]); else n_pass++;
    endtask

    task automatic test_reset_mid_traffic();
        init_upstream_credit = 8'd5; tx_online = 1'b1; tx_valid = 1'b1; tx_data = mk(400);
        rx_push = 1'b1; rx_data = mk(500); rxfifo_ready = 1'b1;
        step(); step(); step(); step();
        n_total++; if (tx_push !== 1'b1) $display("FAIL mid_traffic_push: got %b exp 1", tx_push); else n_pass++;
        rst_wr_n = 1'b0;
        step();
        n_total++; if (rxfifo_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b exp 0", rxfifo_valid); else n_pass++;
        n_total++; if (rxfifo_data !== '0) $display("FAIL mid_rst_rxdata: got %h exp 0", rxfifo_data); else n_pass++;
        n_total++; if (tx_credit_return !== 1'b0) $display("FAIL mid_rst_credit_ret: got %b exp 0", tx_credit_return); else n_pass++;
        n_total++; if (tx_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b exp 0", tx_ready); else n_pass++;
        n_total++; if (tx_push !== 1'b0) $display("FAIL mid_rst_push: got %b exp 0", tx_push); else n_pass++;
        n_total++; if (tx_phy_data !== '0) $display("FAIL mid_rst_phy_data: got %h exp 0", tx_phy_data); else n_pass++;
        n_total++; if (debug_status !== 32'h0) $display("FAIL mid_rst_debug: got %h exp 0", debug_status); else n_pass++;
        rst_wr_n = 1'b1; tx_valid = 1'b0; rx_push = 1'b0; rxfifo_ready = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rx_fill_overflow();
        test_push_pop_full();
        test_tx_credit();
        test_credit_return();
        test_credit_saturate();
        test_rx_flush();
        test_reset_mid_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
